// File: rtl/pipelined_datapath_if.sv
// Purpose: issue, external-load, debug and result/flag signals of the pipelined datapath.
// Latency: none, this is wiring only. The datapath timing lives in pipelined_datapath.
// Backpressure: only the ext load port has any (ext_ready). Issue is always accepted.
interface pipelined_datapath_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              issue_valid;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [ADDR_W-1:0] wa_addr;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_data;
  logic              ext_ready;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_dest;
  logic              flag_zero;
  logic              flag_carry;

  // Issue/load side: decoder, external loader and debug reader.
  modport master (
    output issue_valid, opcode, ra_addr, rb_addr, wa_addr,
    output ext_we, ext_addr, ext_data, dbg_addr,
    input  ext_ready, dbg_data, res_valid, res_data, res_dest, flag_zero, flag_carry
  );

  // Datapath side.
  modport slave (
    input  issue_valid, opcode, ra_addr, rb_addr, wa_addr,
    input  ext_we, ext_addr, ext_data, dbg_addr,
    output ext_ready, dbg_data, res_valid, res_data, res_dest, flag_zero, flag_carry
  );
endinterface

// File: rtl/pipelined_datapath.sv
// Purpose: two-stage (issue/read, execute/writeback) regfile + ALU with forwarding and registered flags.
// Latency: an op issued in cycle N executes in N+1. res_* and the flags are valid during N+2.
// Backpressure: issue never stalls. An ext load is refused (ext_ready=0) while EX owns the write port.
module pipelined_datapath #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_datapath_if.slave   bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_PSA = 4'd8;
  localparam logic [3:0] OP_PSB = 4'd9;
  localparam logic [3:0] OP_ADC = 4'd10;
  localparam logic [3:0] OP_SBB = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              r_ex_valid;
  logic [3:0]        r_ex_op;
  logic [DATA_W-1:0] r_ex_a;
  logic [DATA_W-1:0] r_ex_b;
  logic [ADDR_W-1:0] r_ex_wa;

  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic [ADDR_W-1:0] r_res_dest;
  logic              r_flag_z;
  logic              r_flag_c;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_res;
  logic              w_c_new;
  logic              w_res_vld;
  logic              w_ex_wr;
  logic              w_ext_rdy;
  logic              w_ext_acc;
  logic [DATA_W-1:0] w_ra_val;
  logic [DATA_W-1:0] w_rb_val;

  // EX-stage ALU. Carry defaults to the held flag, so logic/pass ops leave it unchanged.
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_c_new = r_flag_c;
    case (r_ex_op)
      OP_ADD: begin
        w_sum   = {1'b0, r_ex_a} + {1'b0, r_ex_b};
        w_res   = w_sum[DATA_W-1:0];
        w_c_new = w_sum[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        // Bit DATA_W of the widened difference is the borrow, i.e. a < b.
        w_sum   = {1'b0, r_ex_a} - {1'b0, r_ex_b};
        w_res   = w_sum[DATA_W-1:0];
        w_c_new = w_sum[DATA_W];
      end
      OP_AND: w_res = r_ex_a & r_ex_b;
      OP_OR:  w_res = r_ex_a | r_ex_b;
      OP_XOR: w_res = r_ex_a ^ r_ex_b;
      OP_NOT: w_res = ~r_ex_a;
      OP_SHL: begin
        w_res   = {r_ex_a[DATA_W-2:0], 1'b0};
        w_c_new = r_ex_a[DATA_W-1];
      end
      OP_SHR: begin
        w_res   = {1'b0, r_ex_a[DATA_W-1:1]};
        w_c_new = r_ex_a[0];
      end
      OP_PSA: w_res = r_ex_a;
      OP_PSB: w_res = r_ex_b;
      OP_ADC: begin
        w_sum   = {1'b0, r_ex_a} + {1'b0, r_ex_b} + {{DATA_W{1'b0}}, r_flag_c};
        w_res   = w_sum[DATA_W-1:0];
        w_c_new = w_sum[DATA_W];
      end
      OP_SBB: begin
        w_sum   = {1'b0, r_ex_a} - {1'b0, r_ex_b} - {{DATA_W{1'b0}}, r_flag_c};
        w_res   = w_sum[DATA_W-1:0];
        w_c_new = w_sum[DATA_W];
      end
      default: ;
    endcase
  end

  // Opcodes 0-12 produce a result and update flags. Only 0-11 own the write port.
  assign w_res_vld = r_ex_valid && (r_ex_op <= OP_CMP);
  assign w_ex_wr   = r_ex_valid && (r_ex_op <= OP_SBB);
  assign w_ext_rdy = !w_ex_wr;
  assign w_ext_acc = bus.ext_we && w_ext_rdy;

  // IS-stage operand read: EX result first, then the ext write landing this edge, then the regfile.
  always_comb begin
    w_ra_val = r_regs[bus.ra_addr];
    w_rb_val = r_regs[bus.rb_addr];
    if (w_ex_wr && (r_ex_wa == bus.ra_addr)) begin
      w_ra_val = w_res;
    end else if (w_ext_acc && (bus.ext_addr == bus.ra_addr)) begin
      w_ra_val = bus.ext_data;
    end
    if (w_ex_wr && (r_ex_wa == bus.rb_addr)) begin
      w_rb_val = w_res;
    end else if (w_ext_acc && (bus.ext_addr == bus.rb_addr)) begin
      w_rb_val = bus.ext_data;
    end
  end

  // Single regfile write port: EX writeback, else an accepted ext load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_ex_wr) begin
      r_regs[r_ex_wa] <= w_res;
    end else if (w_ext_acc) begin
      r_regs[bus.ext_addr] <= bus.ext_data;
    end
  end

  // EX pipeline register. Payload is captured every cycle and qualified by r_ex_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_wa    <= '0;
    end else begin
      r_ex_valid <= bus.issue_valid;
      r_ex_op    <= bus.opcode;
      r_ex_a     <= w_ra_val;
      r_ex_b     <= w_rb_val;
      r_ex_wa    <= bus.wa_addr;
    end
  end

  // Result stream and flags. Both hold their value across NOPs and idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_dest  <= '0;
      r_flag_z    <= 1'b0;
      r_flag_c    <= 1'b0;
    end else if (w_res_vld) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_res;
      r_res_dest  <= r_ex_wa;
      r_flag_z    <= (w_res == '0);
      r_flag_c    <= w_c_new;
    end else begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.ext_ready  = w_ext_rdy;
  assign bus.dbg_data   = r_regs[bus.dbg_addr];
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_dest   = r_res_dest;
  assign bus.flag_zero  = r_flag_z;
  assign bus.flag_carry = r_flag_c;
endmodule

// File: tb/tb_pipelined_datapath.sv
// Purpose: directed vector table, reset corner cases and a random run checked against a sequential model.
// Latency: each cycle, ext_ready is sampled before the edge and outputs are sampled 1 time unit after it.
// Backpressure: a refused random ext request is held until the datapath accepts it.
module tb_pipelined_datapath;
  localparam int DW = 8;
  localparam int NR = 16;
  localparam int M  = 1 << DW;
  localparam int NRAND = 1500;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pipelined_datapath_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();
  pipelined_datapath #(.DATA_W(DW), .NUM_REGS(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;  logic [3:0] op; logic [3:0] ra; logic [3:0] rb; logic [3:0] wa;
    logic       ew;  logic [3:0] ea; logic [7:0] ed;
    logic       rdy;
    logic       rv;  logic [7:0] rd; logic [3:0] rdst; logic z; logic c;
    logic       dchk; logic [3:0] da; logic [7:0] dd;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input int iv, op, ra, rb, wa, ew, ea, ed, rdy,
                              input int rv, rd, rdst, z, c, dchk, da, dd);
    vec_t m;
    m.iv = 1'(iv); m.op = 4'(op); m.ra = 4'(ra); m.rb = 4'(rb); m.wa = 4'(wa);
    m.ew = 1'(ew); m.ea = 4'(ea); m.ed = 8'(ed); m.rdy = 1'(rdy);
    m.rv = 1'(rv); m.rd = 8'(rd); m.rdst = 4'(rdst); m.z = 1'(z); m.c = 1'(c);
    m.dchk = 1'(dchk); m.da = 4'(da); m.dd = 8'(dd);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] op, ra, rb, wa,
                       input logic ew, input logic [3:0] ea, input logic [7:0] ed,
                       input logic [3:0] da);
    bus.issue_valid = iv; bus.opcode = op;
    bus.ra_addr = ra; bus.rb_addr = rb; bus.wa_addr = wa;
    bus.ext_we = ew; bus.ext_addr = ea; bus.ext_data = ed; bus.dbg_addr = da;
  endtask

  // Arithmetic from the opcode table, done on plain integers.
  function automatic void alu_model(input int op, a, b, cin, output int res, output int c,
                                    output bit zu, output bit wr, output bit rv);
    int s;
    res = 0; c = cin;
    case (op)
      0:  begin s = a + b;       res = s % M; c = int'(s >= M); end
      1, 12: begin res = (a - b + M) % M; c = int'(a < b); end
      2:  res = a & b;
      3:  res = a | b;
      4:  res = a ^ b;
      5:  res = M - 1 - a;
      6:  begin res = (a * 2) % M; c = int'(a >= M / 2); end
      7:  begin res = a / 2;       c = a % 2; end
      8:  res = a;
      9:  res = b;
      10: begin s = a + b + cin; res = s % M; c = int'(s >= M); end
      11: begin res = (a - b - cin + 2 * M) % M; c = int'(a < b + cin); end
      default: ;
    endcase
    zu = (op <= 12); rv = (op <= 12); wr = (op <= 11);
  endfunction

  initial begin
    int mregs [NR];
    int mz, mc;
    bit p_wr, p_rv;
    int p_rd, p_rdst;
    bit q_ew;
    logic [3:0] q_ea;
    logic [7:0] q_ed;

    n_checks = 0;
    n_fail   = 0;

    //           iv op ra rb wa  ew ea ed    rdy rv rd    dst z  c  dchk da dd
    vecs[0]  = mk(0, 0, 0, 0, 0,  1, 1, 'h05, 1,  0, 'h00, 0, 0, 0, 1, 1, 'h05);
    vecs[1]  = mk(0, 0, 0, 0, 0,  1, 2, 'h03, 1,  0, 'h00, 0, 0, 0, 1, 2, 'h03);
    vecs[2]  = mk(1, 0, 1, 2, 3,  0, 0, 'h00, 1,  0, 'h00, 0, 0, 0, 0, 0, 'h00);
    vecs[3]  = mk(0, 0, 0, 0, 0,  0, 0, 'h00, 0,  1, 'h08, 3, 0, 0, 1, 3, 'h08);
    vecs[4]  = mk(1, 0, 1, 2, 4,  0, 0, 'h00, 1,  0, 'h00, 0, 0, 0, 0, 0, 'h00);
    vecs[5]  = mk(1, 1, 4, 1, 5,  0, 0, 'h00, 0,  1, 'h08, 4, 0, 0, 0, 0, 'h00);
    vecs[6]  = mk(1, 4, 5, 5, 6,  0, 0, 'h00, 0,  1, 'h03, 5, 0, 0, 0, 0, 'h00);
    vecs[7]  = mk(0, 0, 0, 0, 0,  0, 0, 'h00, 0,  1, 'h00, 6, 1, 0, 1, 5, 'h03);
    vecs[8]  = mk(0, 0, 0, 0, 0,  1, 1, 'hFF, 1,  0, 'h00, 0, 1, 0, 1, 1, 'hFF);
    vecs[9]  = mk(0, 0, 0, 0, 0,  1, 2, 'h01, 1,  0, 'h00, 0, 1, 0, 1, 2, 'h01);
    vecs[10] = mk(1, 0, 1, 2, 3,  0, 0, 'h00, 1,  0, 'h00, 0, 1, 0, 0, 0, 'h00);
    vecs[11] = mk(1,10, 2, 2, 4,  0, 0, 'h00, 0,  1, 'h00, 3, 1, 1, 0, 0, 'h00);
    vecs[12] = mk(0, 0, 0, 0, 0,  0, 0, 'h00, 0,  1, 'h03, 4, 0, 0, 1, 3, 'h00);
    vecs[13] = mk(1, 0, 1, 2, 3,  0, 0, 'h00, 1,  0, 'h00, 0, 0, 0, 1, 4, 'h03);
    vecs[14] = mk(0, 0, 0, 0, 0,  1, 7, 'hA5, 0,  1, 'h00, 3, 1, 1, 1, 7, 'h00);
    vecs[15] = mk(0, 0, 0, 0, 0,  1, 7, 'hA5, 1,  0, 'h00, 0, 1, 1, 1, 7, 'hA5);
    vecs[16] = mk(1,12, 2, 1, 9,  0, 0, 'h00, 1,  0, 'h00, 0, 1, 1, 0, 0, 'h00);
    vecs[17] = mk(1,14, 1, 1, 2,  0, 0, 'h00, 1,  1, 'h02, 9, 0, 1, 1, 9, 'h00);
    vecs[18] = mk(0, 0, 0, 0, 0,  0, 0, 'h00, 1,  0, 'h00, 0, 0, 1, 1, 2, 'h01);

    // Reset state.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_dest", bus.res_dest, 0);
    chk("rst_flag_zero", bus.flag_zero, 0);
    chk("rst_flag_carry", bus.flag_carry, 0);
    chk("rst_ext_ready", bus.ext_ready, 1);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].iv, vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].wa,
            vecs[i].ew, vecs[i].ea, vecs[i].ed, vecs[i].da);
      #1;
      chk($sformatf("v%0d_ext_ready", i), bus.ext_ready, vecs[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_res_valid", i), bus.res_valid, vecs[i].rv);
      if (vecs[i].rv) begin
        chk($sformatf("v%0d_res_data", i), bus.res_data, vecs[i].rd);
        chk($sformatf("v%0d_res_dest", i), bus.res_dest, vecs[i].rdst);
      end
      chk($sformatf("v%0d_flag_zero", i), bus.flag_zero, vecs[i].z);
      chk($sformatf("v%0d_flag_carry", i), bus.flag_carry, vecs[i].c);
      if (vecs[i].dchk) chk($sformatf("v%0d_dbg_data", i), bus.dbg_data, vecs[i].dd);
    end

    // Reset while an ADD (R10 = 0xFF + 0xFF) sits in EX: writeback must be dropped.
    drive(1, 0, 1, 1, 10, 0, 0, 0, 10);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 1, 11, 'h77, 10);
    rst_n = 1'b0;
    #1;
    chk("midrst_ext_ready_busy", bus.ext_ready, 0);
    @(posedge clk);
    #1;
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_flag_zero", bus.flag_zero, 0);
    chk("midrst_flag_carry", bus.flag_carry, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midrst_ext_ready", bus.ext_ready, 1);
    for (int r = 0; r < NR; r++) begin
      bus.dbg_addr = 4'(r);
      #1;
      chk($sformatf("midrst_reg%0d", r), bus.dbg_data, 0);
    end
    @(posedge clk);
    #1;
    chk("midrst_res_valid_after", bus.res_valid, 0);

    // Random run against a sequential model: each op is applied to the model at issue,
    // the DUT shows it one edge later.
    for (int r = 0; r < NR; r++) mregs[r] = 0;
    mz = 0; mc = 0; p_wr = 0; p_rv = 0; p_rd = 0; p_rdst = 0;
    q_ew = 0; q_ea = '0; q_ed = '0;
    for (int t = 0; t < NRAND + 3; t++) begin
      logic iv;
      logic [3:0] op, ra, rb, wa;
      bit exp_rdy, e_rv;
      int e_rd, e_rdst, ez, ec, res, c;
      bit zu, wr, rv;
      iv = (t < NRAND) && ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 7));
      rb = 4'($urandom_range(0, 7));
      wa = 4'($urandom_range(0, 7));
      if (!q_ew && t < NRAND && $urandom_range(0, 2) == 0) begin
        q_ew = 1; q_ea = 4'($urandom_range(0, 7)); q_ed = 8'($urandom_range(0, 255));
      end
      drive(iv, op, ra, rb, wa, q_ew, q_ea, q_ed, 0);
      exp_rdy = !p_wr;
      #1;
      chk("rand_ext_ready", bus.ext_ready, exp_rdy);
      ez = mz; ec = mc; e_rv = p_rv; e_rd = p_rd; e_rdst = p_rdst;
      if (q_ew && exp_rdy) mregs[q_ea] = q_ed;
      if (iv) begin
        alu_model(op, mregs[ra], mregs[rb], mc, res, c, zu, wr, rv);
        if (wr) mregs[wa] = res;
        if (zu) begin mz = int'(res == 0); mc = c; end
        p_wr = wr; p_rv = rv; p_rd = res; p_rdst = wa;
      end else begin
        p_wr = 0; p_rv = 0;
      end
      @(posedge clk);
      #1;
      if (q_ew && exp_rdy) q_ew = 0;
      chk("rand_res_valid", bus.res_valid, e_rv);
      if (e_rv) begin
        chk("rand_res_data", bus.res_data, e_rd);
        chk("rand_res_dest", bus.res_dest, e_rdst);
      end
      chk("rand_flag_zero", bus.flag_zero, ez);
      chk("rand_flag_carry", bus.flag_carry, ec);
    end
    chk("rand_ext_drained", q_ew, 0);
    for (int r = 0; r < NR; r++) begin
      bus.dbg_addr = 4'(r);
      #1;
      chk($sformatf("rand_reg%0d", r), bus.dbg_data, mregs[r]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
